// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the core
// load/store port (0) and the debug/loader port (1).
module dmem_arbiter #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          last;
  logic [1:0]    grant;
  logic          gnt;
  logic          sel;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata;
  logic          gwe;
  logic          legal;

  // On contention the port that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      grant[0] = req_valid[0] & (~req_valid[1] | last);
      grant[1] = req_valid[1] & (~req_valid[0] | ~last);
    end
  end

  assign gnt    = |grant;
  assign sel    = grant[1];
  assign gaddr  = sel ? req_addr1  : req_addr0;
  assign gwdata = sel ? req_wdata1 : req_wdata0;
  assign gwe    = sel ? req_we[1]  : req_we[0];
  assign legal  = 32'(gaddr) < DEPTH;

  assign req_ready = grant;
  assign mem_write = gnt & gwe & legal;
  assign mem_read  = gnt & ~gwe & legal;
  assign mem_addr  = gnt ? gaddr : '0;
  assign mem_wdata = gnt ? gwdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant;
      rsp_err   <= gnt & ~legal;
      rsp_rdata <= mem_read ? mem_rdata : '0;
      if (gnt)
        last <= sel;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a memory device model
// and an independent reference model compared every cycle.
module tb_dmem_arbiter;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory device, cleared by reset.
  logic [DW-1:0] dmem [16];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else if (mem_write) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model.
  int            prev;
  logic [DW-1:0] ref_mem [16];
  logic [1:0]    e_rv;
  logic [DW-1:0] e_rd;
  logic          e_re;

  function automatic logic [1:0] mgrant(input logic r,
                                        input logic [1:0] v,
                                        input int p);
    if (r) return 2'b00;
    if (v == 2'b11) return (p == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  logic [1:0]    eg;
  logic          ep;
  logic [AW-1:0] eaddr;
  logic [DW-1:0] ewdata;
  logic          ewe, elegal, eread, ewrite;
  assign eg     = mgrant(rst, req_valid, prev);
  assign ep     = (eg == 2'b10);
  assign eaddr  = (eg == 2'b00) ? '0 : (ep ? req_addr1 : req_addr0);
  assign ewdata = (eg == 2'b00) ? '0 : (ep ? req_wdata1 : req_wdata0);
  assign ewe    = ep ? req_we[1] : req_we[0];
  assign elegal = int'(eaddr) < DEPTH;
  assign eread  = (eg != 2'b00) && !ewe && elegal;
  assign ewrite = (eg != 2'b00) && ewe && elegal;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1;
      e_rv <= 2'b00;
      e_rd <= '0;
      e_re <= 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] <= '0;
    end else begin
      e_rv <= eg;
      e_re <= (eg != 2'b00) && !elegal;
      e_rd <= eread ? ref_mem[eaddr] : '0;
      if (ewrite) ref_mem[eaddr] <= ewdata;
      if (eg != 2'b00) prev <= ep ? 1 : 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_ready", 64'(req_ready), 64'(eg));
    check("m_mem_read", 64'(mem_read), 64'(eread));
    check("m_mem_write", 64'(mem_write), 64'(ewrite));
    check("m_mem_addr", 64'(mem_addr), 64'(eaddr));
    check("m_mem_wdata", 64'(mem_wdata), 64'(ewdata));
    check("m_rsp_valid", 64'(rsp_valid), 64'(e_rv));
    check("m_rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    check("m_rsp_err", 64'(rsp_err), 64'(e_re));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req_valid  = v;
    req_we     = we;
    req_addr0  = a0;
    req_wdata0 = d0;
    req_addr1  = a1;
    req_wdata1 = d1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next();
    next();
    rst = 1'b0;
  endtask

  logic [1:0] exp_g [4];

  initial begin
    rst = 1'b1;
    idle();
    neg();
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
    next();
    rst = 1'b0;

    // Port 0 write then read of addr 3.
    drive(2'b01, 2'b01, 4'd3, 32'hDEADBEEF, '0, '0);
    neg();
    check("wr_ready", 64'(req_ready), 64'd1);
    check("wr_mem_write", 64'(mem_write), 64'd1);
    next();
    drive(2'b01, 2'b00, 4'd3, '0, '0, '0);
    neg();
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_err", 64'(rsp_err), 64'd0);
    next();
    idle();
    neg();
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    next();

    // Both ports reading continuously: alternating grants.
    do_reset();
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    drive(2'b11, 2'b00, 4'd1, '0, 4'd2, '0);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("rr_grant", 64'(req_ready), 64'(exp_g[i]));
      if (i > 0) check("rr_rsp", 64'(rsp_valid), 64'(exp_g[i-1]));
      next();
    end
    idle();
    neg();
    check("rr_rsp_last", 64'(rsp_valid), 64'(exp_g[3]));
    next();

    // Port 1 write then read of the last legal address.
    drive(2'b10, 2'b10, '0, '0, 4'd9, 32'h12345678);
    neg();
    check("p1_wr_ready", 64'(req_ready), 64'd2);
    next();
    drive(2'b10, 2'b00, '0, '0, 4'd9, '0);
    neg();
    check("p1_wr_err", 64'(rsp_err), 64'd0);
    next();
    idle();
    neg();
    check("p1_rd_rsp", 64'(rsp_valid), 64'd2);
    check("p1_rd_data", 64'(rsp_rdata), 64'h12345678);
    check("p1_rd_err", 64'(rsp_err), 64'd0);
    next();

    // Illegal addresses do not touch memory.
    drive(2'b01, 2'b01, 4'd0, 32'h0000A5A5, '0, '0);
    next();
    drive(2'b01, 2'b01, 4'd10, 32'hFFFFFFFF, '0, '0);
    neg();
    check("ill_wr_strobe", 64'({mem_read, mem_write}), 64'd0);
    check("ill_wr_ready", 64'(req_ready), 64'd1);
    next();
    drive(2'b01, 2'b00, 4'd15, '0, '0, '0);
    neg();
    check("ill_wr_err", 64'(rsp_err), 64'd1);
    check("ill_wr_rdata", 64'(rsp_rdata), 64'd0);
    check("ill_rd_strobe", 64'({mem_read, mem_write}), 64'd0);
    next();
    drive(2'b01, 2'b00, 4'd0, '0, '0, '0);
    neg();
    check("ill_rd_err", 64'(rsp_err), 64'd1);
    check("ill_rd_rdata", 64'(rsp_rdata), 64'd0);
    next();
    idle();
    neg();
    check("addr0_intact", 64'(rsp_rdata), 64'h0000A5A5);
    next();

    // Port 0 streams writes while port 1 reads.
    drive(2'b01, 2'b01, 4'd4, 32'd100, '0, '0);
    next();
    drive(2'b11, 2'b01, 4'd5, 32'd101, 4'd4, '0);
    neg();
    check("st_p1_grant", 64'(req_ready), 64'd2);
    next();
    drive(2'b01, 2'b01, 4'd5, 32'd101, '0, '0);
    neg();
    check("st_p0_grant", 64'(req_ready), 64'd1);
    check("st_p1_rsp", 64'(rsp_valid), 64'd2);
    check("st_p1_rdata", 64'(rsp_rdata), 64'd100);
    next();
    idle();
    neg();
    check("st_p0_rsp", 64'(rsp_valid), 64'd1);
    next();

    // Reset while a port 0 read response is pending.
    drive(2'b01, 2'b00, 4'd4, '0, '0, '0);
    next();
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("rst_rsp_drop", 64'(rsp_valid), 64'd0);
    next();
    drive(2'b11, 2'b00, 4'd4, '0, 4'd5, '0);
    neg();
    check("rst_hold_ready", 64'(req_ready), 64'd0);
    next();
    rst = 1'b0;
    neg();
    check("rst_first_grant", 64'(req_ready), 64'd1);
    next();
    idle();
    neg();
    check("rst_mem_cleared", 64'(rsp_rdata), 64'd0);
    next();
    next();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the core load/store path (port 0) and the debug/loader port (port 1). Each cycle it grants at most one request with round-robin fairness and drives the memory's `mem_read`/`mem_write`/`address`/`write_data` strobes. It returns read data and an error flag to the granted requester one cycle later. It sits between the requesters and the data memory; the memory itself is unchanged.

## Interface
Parameters:
- `DEPTH`, 10: number of implemented memory words; legal addresses are 0..DEPTH-1.
- `AW`, 4: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_we[1:0]`  in  2  per-port write enable: 1 = write, 0 = read.
- `req_addr0`, `req_addr1`  in  AW  per-port word address.
- `req_wdata0`, `req_wdata1`  in  DW  per-port write data.
- `req_ready[1:0]`  out  2  grant; handshake completes when valid&ready.
- `rsp_valid[1:0]`  out  2  one-cycle response pulse, per port.
- `rsp_rdata`  out  DW  read data for the responding port (0 for writes and errors).
- `rsp_err`  out  1  the address of the responding request was ≥ DEPTH.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory combinational read data.

## Operation
- Internal state:
  - `last` (1 bit): the port granted most recently. Reset value 1, so port 0 wins first.
  - Response registers.
- Arbitration is combinational in each cycle:
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port ≠ `last` is granted.
  - `req_ready` is one-hot or zero, and is never asserted for a port whose `req_valid` is low.
- Granted access:
  - `mem_addr` and `mem_wdata` are muxed from the granted port.
  - `mem_write` = granted & we & legal address.
  - `mem_read` = granted & !we & legal address.
  - When nothing is granted, all mem outputs are 0.
- An address ≥ DEPTH is illegal:
  - No memory strobe is asserted.
  - The request is still handshaken.
  - Its response carries `rsp_err`=1 and `rsp_rdata`=0.
- `last` updates to the granted port on every grant. It holds when there is no grant.
- Requesters must hold `req_valid`, `req_we`, address and data stable until they see ready. Dropping valid before ready is legal: the request is withdrawn and never executed.
- Responses have no backpressure; a requester must accept `rsp_valid` whenever it occurs.
- Ports may issue back-to-back requests. A new request may be presented in the same cycle its previous response pulse is visible.

## Timing
- Grant latency is 0 cycles: an uncontended valid is granted in the same cycle.
- With both ports valid continuously, grants alternate every cycle: 0,1,0,1…
- Memory access happens in the grant cycle N.
  - A write commits at the rising edge ending cycle N.
  - On a read, `mem_rdata` is sampled at that same edge.
- Response appears in cycle N+1:
  - `rsp_valid[p]` is high for exactly one cycle.
  - `rsp_rdata` and `rsp_err` are valid only while some `rsp_valid` bit is high.
  - Outside a response, both are 0.
- A read in cycle N+1 of an address written in cycle N returns the new data.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `mem_*` outputs 0, `last`=1.
- Reset mid-operation:
  - Asserting rst clears a pending response immediately (asynchronous); that response is lost.
  - A write granted in the same cycle as reset assertion is not guaranteed.
  - While rst is high, `req_ready` stays 0.
  - The first grant is possible in the first cycle after rst deasserts.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to addr 3; then port 0 reads addr 3. Required:
  - Write: `req_ready[0]` in the request cycle and `rsp_valid[0]` next cycle with `rsp_err`=0.
  - Read: response next cycle with `rsp_rdata`=0xDEADBEEF.
- Both ports hold valid reads, to addrs 1 and 2, for 4 cycles after reset. Required:
  - Grants go 0,1,0,1.
  - Responses go to the matching port one cycle later each.
  - No cycle has both ready bits high.
- Port 1 writes 0x12345678 to addr 9, then immediately reads addr 9 on the next cycle. Required:
  - The read returns 0x12345678.
  - The boundary address is legal, so `rsp_err`=0.
- Port 0 writes 0xFFFFFFFF to addr 10, then reads addr 15. Required:
  - `mem_write` and `mem_read` are never asserted.
  - Both responses have `rsp_err`=1 and `rsp_rdata`=0.
  - A read of addr 0 afterwards returns its prior value.
- Port 0 streams writes every cycle while port 1 raises a read. Required:
  - Port 1 is granted no later than the second cycle after it raises valid.
  - Port 0's stalled request is held and completes on the next cycle.
- Assert rst in the cycle a port 0 read response is pending. Required:
  - `rsp_valid` drops to 0 immediately.
  - After release, memory reads as 0.
  - The first request is granted to port 0 when both are valid.
